// File: rtl/oven_cook_sequencer_pkg.sv
// Shared types and widths for the oven cooking-cycle sequencer.
package oven_pkg;

  parameter int TEMP_W = 8;
  parameter int TIME_W = 8;

  typedef enum logic [2:0] {IDLE, PREHEAT, COOK, PAUSE, DONE} oven_state_t;
  typedef enum logic [1:0] {OFF, BAKE, GRILL, CONV} oven_mode_t;

  // Subtraction that stops at zero instead of wrapping.
  function automatic logic [TEMP_W-1:0] sat_sub(input logic [TEMP_W-1:0] a,
                                                input logic [TEMP_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/oven_cook_sequencer_if.sv
// Control and actuator bundle between the register block (master) and the sequencer (slave).
interface oven_cook_sequencer_if ();
  import oven_pkg::*;

  logic              start;
  logic              cancel;
  logic              door_closed;
  oven_mode_t        mode;
  logic [TIME_W-1:0] timp_setat;
  logic [TEMP_W-1:0] temp_target;
  logic [TEMP_W-1:0] temp_current;
  logic              heat_top;
  logic              heat_bot;
  logic              fan_en;
  logic              mod_ready;
  logic [TIME_W-1:0] timer_remain;
  logic              timeout;
  logic              busy;

  modport master (
    output start, cancel, door_closed, mode, timp_setat, temp_target, temp_current,
    input  heat_top, heat_bot, fan_en, mod_ready, timer_remain, timeout, busy
  );

  modport slave (
    input  start, cancel, door_closed, mode, timp_setat, temp_target, temp_current,
    output heat_top, heat_bot, fan_en, mod_ready, timer_remain, timeout, busy
  );

endinterface

// File: rtl/oven_cook_sequencer_tick_gen.sv
// Time-unit prescaler: emits a one-clock tick every TICK_DIV enabled cycles.
module oven_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/oven_cook_sequencer.sv
// Cooking-cycle controller: sequences preheat, cook and done, runs the thermostat
// and the cook timer, and drives the heater/fan enables and status outputs.
module oven_cook_sequencer
  import oven_pkg::*;
#(
  parameter int unsigned       TICK_DIV  = 50_000_000,
  parameter logic [TEMP_W-1:0] HYST      = 8'd5,
  parameter logic [7:0]        DONE_HOLD = 8'd10
) (
  input logic                  clk,
  input logic                  reset,
  oven_cook_sequencer_if.slave bus
);

  oven_state_t       state_q, state_d;
  oven_state_t       ret_q, ret_d;
  oven_mode_t        mode_l_q, mode_l_d;
  logic [TEMP_W-1:0] target_l_q, target_l_d;
  logic [TIME_W-1:0] timer_q, timer_d;
  logic [7:0]        hold_q, hold_d;
  logic              heat_req_q, heat_req_d;
  logic              heat_top_q, heat_top_d;
  logic              heat_bot_q, heat_bot_d;
  logic              fan_q, fan_d;
  logic              ready_q, ready_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;
  logic              door_meta_q, door_s_q;
  logic              tick, tick_en, tick_clr;
  logic              ready_now, heating_d;
  logic [TEMP_W-1:0] on_thresh;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      door_meta_q <= 1'b0;
      door_s_q    <= 1'b0;
    end else begin
      door_meta_q <= bus.door_closed;
      door_s_q    <= door_meta_q;
    end
  end

  // The prescaler is held at zero outside COOK/DONE, so every entry into COOK starts a full period.
  assign tick_en  = (state_q == COOK) || (state_q == DONE);
  assign tick_clr = !tick_en;

  oven_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (tick_en),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_comb begin
    ready_now  = door_s_q && (bus.timp_setat != '0) && (bus.mode != OFF);
    state_d    = state_q;
    ret_d      = ret_q;
    mode_l_d   = mode_l_q;
    target_l_d = target_l_q;
    timer_d    = timer_q;
    hold_d     = hold_q;
    timeout_d  = 1'b0;

    // Cancel beats door, door beats the final tick, and the tick beats start.
    if (bus.cancel) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && ready_now) begin
            state_d    = PREHEAT;
            mode_l_d   = bus.mode;
            target_l_d = bus.temp_target;
            timer_d    = bus.timp_setat;
          end
        end
        PREHEAT: begin
          if (!door_s_q) begin
            state_d = PAUSE;
            ret_d   = PREHEAT;
          end else if (bus.temp_current >= target_l_q) begin
            state_d = COOK;
          end
        end
        COOK: begin
          if (!door_s_q) begin
            state_d = PAUSE;
            ret_d   = COOK;
          end else if (tick) begin
            if (timer_q <= TIME_W'(1)) begin
              timer_d   = '0;
              timeout_d = 1'b1;
              hold_d    = '0;
              state_d   = DONE;
            end else begin
              timer_d = timer_q - TIME_W'(1);
            end
          end
        end
        PAUSE: begin
          if (bus.start && door_s_q) begin
            state_d = ret_q;
          end
        end
        DONE: begin
          if (!door_s_q) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (tick) begin
            if (hold_q + 8'd1 >= DONE_HOLD) begin
              state_d = IDLE;
              timer_d = '0;
            end else begin
              hold_d = hold_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end

    case (state_d)
      IDLE:    ready_d = ready_now;
      DONE:    ready_d = (state_q != DONE) ? 1'b1 : (tick ? !ready_q : ready_q);
      default: ready_d = 1'b0;
    endcase

    // Thermostat and actuators follow the next state so the registered outputs line up with it.
    heating_d  = (state_d == PREHEAT) || (state_d == COOK);
    on_thresh  = sat_sub(target_l_d, HYST);
    heat_req_d = heat_req_q;
    if (!heating_d) begin
      heat_req_d = 1'b0;
    end else if (bus.temp_current >= target_l_d) begin
      heat_req_d = 1'b0;
    end else if (bus.temp_current < on_thresh) begin
      heat_req_d = 1'b1;
    end

    heat_top_d = heat_req_d && (mode_l_d != OFF);
    heat_bot_d = heat_req_d && ((mode_l_d == BAKE) || (mode_l_d == CONV));
    fan_d      = heating_d && (mode_l_d == CONV);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ret_q      <= PREHEAT;
      mode_l_q   <= OFF;
      target_l_q <= '0;
      timer_q    <= '0;
      hold_q     <= '0;
      heat_req_q <= 1'b0;
      heat_top_q <= 1'b0;
      heat_bot_q <= 1'b0;
      fan_q      <= 1'b0;
      ready_q    <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      mode_l_q   <= mode_l_d;
      target_l_q <= target_l_d;
      timer_q    <= timer_d;
      hold_q     <= hold_d;
      heat_req_q <= heat_req_d;
      heat_top_q <= heat_top_d;
      heat_bot_q <= heat_bot_d;
      fan_q      <= fan_d;
      ready_q    <= ready_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.heat_top     = heat_top_q;
  assign bus.heat_bot     = heat_bot_q;
  assign bus.fan_en       = fan_q;
  assign bus.mod_ready    = ready_q;
  assign bus.timer_remain = timer_q;
  assign bus.timeout      = timeout_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_oven_cook_sequencer.sv
// Scenario bench for oven_cook_sequencer with a short prescaler (TICK_DIV=4, HYST=5, DONE_HOLD=3).
module tb_oven_cook_sequencer;
  import oven_pkg::*;

  typedef struct {
    logic [7:0] timer;
    logic       timeout;
    int         gap;
  } exp_evt_t;

  logic       clk = 1'b0;
  logic       reset;
  int         n_checks = 0;
  int         n_fail = 0;
  exp_evt_t   evt_q[$];
  logic [1:0] heat_q[$];

  oven_cook_sequencer_if bus ();

  oven_cook_sequencer #(
    .TICK_DIV  (4),
    .HYST      (8'd5),
    .DONE_HOLD (8'd3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_cancel();
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
  endtask

  task automatic wait_timer_change(input int budget, output int cyc, output bit ok);
    logic [7:0] prev;
    prev = bus.timer_remain;
    cyc  = 0;
    ok   = 1'b0;
    while (!ok && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.timer_remain !== prev) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset            = 1'b0;
    bus.start        = 1'b0;
    bus.cancel       = 1'b0;
    bus.door_closed  = 1'b0;
    bus.mode         = OFF;
    bus.timp_setat   = 8'd0;
    bus.temp_target  = 8'd0;
    bus.temp_current = 8'd0;
    cycles(3);
    n_checks++;
    if ({bus.heat_top, bus.heat_bot, bus.fan_en, bus.mod_ready, bus.timeout, bus.busy} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b, want 000000",
               {bus.heat_top, bus.heat_bot, bus.fan_en, bus.mod_ready, bus.timeout, bus.busy});
    end
    n_checks++;
    if (bus.timer_remain !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_timer: got %0d, want 0", bus.timer_remain);
    end
    reset = 1'b1;
    cycles(2);
  endtask

  task automatic test_idle_ready();
    bus.door_closed  = 1'b1;
    bus.mode         = BAKE;
    bus.timp_setat   = 8'd2;
    bus.temp_target  = 8'd100;
    bus.temp_current = 8'd50;
    cycles(4);
    n_checks++;
    if (bus.mod_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL idle_ready_on: got %b, want 1", bus.mod_ready);
    end
    bus.timp_setat = 8'd0;
    cycles(2);
    n_checks++;
    if (bus.mod_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_ready_timp0: got %b, want 0", bus.mod_ready);
    end
    pulse_start();
    cycles(2);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_start_ignored: busy got %b, want 0", bus.busy);
    end
    bus.timp_setat = 8'd2;
    cycles(2);
  endtask

  task automatic test_bake_cycle();
    exp_evt_t e;
    int       cyc;
    bit       ok;
    int       done_cyc;
    logic     blink_val;
    bus.mode         = BAKE;
    bus.timp_setat   = 8'd2;
    bus.temp_target  = 8'd100;
    bus.temp_current = 8'd50;
    pulse_start();
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bake_busy: got %b, want 1", bus.busy);
    end
    n_checks++;
    if ({bus.heat_top, bus.heat_bot} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL bake_preheat_heat: got %b, want 11", {bus.heat_top, bus.heat_bot});
    end
    n_checks++;
    if (bus.timer_remain !== 8'd2) begin
      n_fail++;
      $display("[TB] FAIL bake_timer_load: got %0d, want 2", bus.timer_remain);
    end
    bus.temp_current = 8'd100;
    cycles(1);
    n_checks++;
    if ({bus.heat_top, bus.heat_bot} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL bake_cook_heat_off: got %b, want 00", {bus.heat_top, bus.heat_bot});
    end
    evt_q.push_back('{8'd1, 1'b0, 4});
    evt_q.push_back('{8'd0, 1'b1, 4});
    while (evt_q.size() > 0) begin
      wait_timer_change(20, cyc, ok);
      e = evt_q.pop_front();
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("[TB] FAIL bake_timer_event: no change in 20 cycles, want timer %0d", e.timer);
        evt_q.delete();
      end else begin
        if (bus.timer_remain !== e.timer) begin
          n_fail++;
          $display("[TB] FAIL bake_timer_value: got %0d, want %0d", bus.timer_remain, e.timer);
        end
        n_checks++;
        if (bus.timeout !== e.timeout) begin
          n_fail++;
          $display("[TB] FAIL bake_timeout: got %b, want %b", bus.timeout, e.timeout);
        end
        n_checks++;
        if (cyc != e.gap) begin
          n_fail++;
          $display("[TB] FAIL bake_tick_gap: got %0d clk, want %0d clk", cyc, e.gap);
        end
      end
    end
    n_checks++;
    if (bus.mod_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL done_ready_on: got %b, want 1", bus.mod_ready);
    end
    cycles(1);
    n_checks++;
    if (bus.timeout !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL timeout_width: got %b one clk later, want 0", bus.timeout);
    end
    done_cyc  = 1;
    blink_val = 1'bx;
    while (bus.busy === 1'b1 && done_cyc < 40) begin
      @(negedge clk);
      done_cyc++;
      if (done_cyc == 4) blink_val = bus.mod_ready;
    end
    n_checks++;
    if (done_cyc != 12) begin
      n_fail++;
      $display("[TB] FAIL done_hold_len: busy fell after %0d clk, want 12", done_cyc);
    end
    n_checks++;
    if (blink_val !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL done_blink: got %b after first hold tick, want 0", blink_val);
    end
    n_checks++;
    if (bus.timer_remain !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL done_timer_clear: got %0d, want 0", bus.timer_remain);
    end
  endtask

  task automatic test_thermostat();
    logic [7:0] temps [5];
    logic [1:0] heats [5];
    logic [1:0] exp_h;
    temps = '{8'd100, 8'd96, 8'd94, 8'd99, 8'd100};
    heats = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b00};
    bus.mode         = BAKE;
    bus.timp_setat   = 8'd20;
    bus.temp_target  = 8'd100;
    bus.temp_current = 8'd100;
    pulse_start();
    cycles(1);
    for (int i = 0; i < 5; i++) begin
      bus.temp_current = temps[i];
      heat_q.push_back(heats[i]);
      cycles(1);
      exp_h = heat_q.pop_front();
      n_checks++;
      if ({bus.heat_top, bus.heat_bot} !== exp_h) begin
        n_fail++;
        $display("[TB] FAIL thermostat_temp%0d: heaters got %b, want %b", temps[i],
                 {bus.heat_top, bus.heat_bot}, exp_h);
      end
    end
    pulse_cancel();
    n_checks++;
    if ({bus.busy, bus.timeout, bus.timer_remain} !== 10'd0) begin
      n_fail++;
      $display("[TB] FAIL cook_cancel: busy/timeout/timer got %b/%b/%0d, want 0/0/0",
               bus.busy, bus.timeout, bus.timer_remain);
    end
  endtask

  task automatic test_door_pause();
    exp_evt_t e;
    int       cyc;
    bit       ok;
    bus.mode         = BAKE;
    bus.timp_setat   = 8'd5;
    bus.temp_target  = 8'd100;
    bus.temp_current = 8'd100;
    pulse_start();
    cycles(1);
    bus.door_closed  = 1'b0;
    bus.temp_current = 8'd50;
    cycles(4);
    n_checks++;
    if (bus.timer_remain !== 8'd5) begin
      n_fail++;
      $display("[TB] FAIL pause_timer_hold: got %0d, want 5", bus.timer_remain);
    end
    n_checks++;
    if ({bus.heat_top, bus.heat_bot, bus.fan_en} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL pause_actuators_off: got %b, want 000",
               {bus.heat_top, bus.heat_bot, bus.fan_en});
    end
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL pause_busy: got %b, want 1", bus.busy);
    end
    bus.door_closed = 1'b1;
    cycles(10);
    n_checks++;
    if (bus.timer_remain !== 8'd5 || {bus.heat_top, bus.heat_bot} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL pause_door_only: timer/heat got %0d/%b, want 5/00",
               bus.timer_remain, {bus.heat_top, bus.heat_bot});
    end
    pulse_start();
    n_checks++;
    if ({bus.heat_top, bus.heat_bot} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL resume_heat: got %b, want 11", {bus.heat_top, bus.heat_bot});
    end
    evt_q.push_back('{8'd4, 1'b0, 4});
    wait_timer_change(20, cyc, ok);
    e = evt_q.pop_front();
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL resume_decrement: no change in 20 cycles, want timer %0d", e.timer);
    end else begin
      if (bus.timer_remain !== e.timer || cyc != e.gap) begin
        n_fail++;
        $display("[TB] FAIL resume_decrement: got %0d after %0d clk, want %0d after %0d clk",
                 bus.timer_remain, cyc, e.timer, e.gap);
      end
    end
    pulse_cancel();
    cycles(1);
  endtask

  task automatic test_collisions();
    bit seen;
    bus.mode         = BAKE;
    bus.timp_setat   = 8'd3;
    bus.temp_target  = 8'd100;
    bus.temp_current = 8'd50;
    pulse_start();
    pulse_cancel();
    n_checks++;
    if ({bus.busy, bus.timer_remain, bus.heat_top, bus.heat_bot} !== 11'd0) begin
      n_fail++;
      $display("[TB] FAIL preheat_cancel: busy/timer/heat got %b/%0d/%b, want 0/0/00",
               bus.busy, bus.timer_remain, {bus.heat_top, bus.heat_bot});
    end
    seen = (bus.timeout === 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.timeout === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("[TB] FAIL preheat_cancel_timeout: got pulse, want none");
    end

    bus.timp_setat   = 8'd1;
    bus.temp_current = 8'd100;
    pulse_start();
    cycles(2);
    bus.door_closed = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.timeout === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (bus.timer_remain !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL final_tick_door_timer: got %0d, want 1", bus.timer_remain);
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("[TB] FAIL final_tick_door_timeout: got pulse, want none");
    end
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL final_tick_door_pause: busy got %b, want 1", bus.busy);
    end
    bus.door_closed = 1'b1;
    pulse_cancel();
    cycles(3);
  endtask

  task automatic test_grill_conv();
    bus.mode         = GRILL;
    bus.timp_setat   = 8'd3;
    bus.temp_target  = 8'd100;
    bus.temp_current = 8'd50;
    pulse_start();
    n_checks++;
    if ({bus.heat_top, bus.heat_bot, bus.fan_en} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL grill_heaters: top/bot/fan got %b, want 100",
               {bus.heat_top, bus.heat_bot, bus.fan_en});
    end
    pulse_cancel();
    bus.mode         = CONV;
    bus.temp_current = 8'd100;
    pulse_start();
    n_checks++;
    if ({bus.heat_top, bus.heat_bot, bus.fan_en} !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL conv_fan_preheat: top/bot/fan got %b, want 001",
               {bus.heat_top, bus.heat_bot, bus.fan_en});
    end
    bus.mode = BAKE;
    cycles(2);
    n_checks++;
    if (bus.fan_en !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL conv_fan_latched: got %b, want 1", bus.fan_en);
    end
  endtask

  task automatic test_reset_midcook();
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.heat_top, bus.heat_bot, bus.fan_en, bus.mod_ready, bus.timeout, bus.busy} !== 6'b0 ||
        bus.timer_remain !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_async: flags/timer got %b/%0d, want 000000/0",
               {bus.heat_top, bus.heat_bot, bus.fan_en, bus.mod_ready, bus.timeout, bus.busy},
               bus.timer_remain);
    end
    @(negedge clk);
    reset = 1'b1;
    cycles(6);
    n_checks++;
    if ({bus.busy, bus.fan_en, bus.timer_remain} !== 10'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_no_resume: busy/fan/timer got %b/%b/%0d, want 0/0/0",
               bus.busy, bus.fan_en, bus.timer_remain);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ready();
    test_bake_cycle();
    test_thermostat();
    test_door_pause();
    test_collisions();
    test_grill_conv();
    test_reset_midcook();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
